// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with edge-triggered operand entry, single-cycle ops,
// a shift-add multiplier with busy/done handshake and optional accumulator mode.
module alu_seq #(
  parameter int WIDTH = 8,
  parameter bit CHAIN = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] data_in,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_hi,
  output logic [3:0]       flags,
  output logic             busy,
  output logic             done,
  output logic [1:0]       phase
);

  localparam int SW = $clog2(WIDTH);
  localparam logic [SW:0]   W_L      = (SW+1)'(WIDTH);
  localparam logic [SW-1:0] CNT_LAST = SW'(WIDTH-1);

  typedef enum logic [1:0] {S_LOAD_A = 2'd0, S_LOAD_B = 2'd1, S_READY = 2'd2, S_BUSY = 2'd3} state_e;
  typedef enum logic [3:0] {
    OP_ADD = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_OR  = 4'h3,
    OP_XOR = 4'h4, OP_NOT = 4'h5, OP_SHL = 4'h6, OP_SHR = 4'h7,
    OP_SRA = 4'h8, OP_ROL = 4'h9, OP_ROR = 4'hA, OP_MUL = 4'hB,
    OP_CMP = 4'hC, OP_INC = 4'hD, OP_DEC = 4'hE, OP_RLD = 4'hF
  } op_e;

  state_e             state_q, state_d;
  logic               en_q;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, y_q, y_d, yh_q, yh_d;
  logic [3:0]         fl_q, fl_d;
  logic               done_q, done_d, busy_q, busy_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [SW-1:0]      cnt_q, cnt_d;

  logic               edge_s;
  logic [SW-1:0]      sh_s;
  logic [WIDTH:0]     add_s, sub_s, mul_sum_s;
  logic [2*WIDTH-1:0] mul_next_s;
  logic [WIDTH-1:0]   alu_y_s;
  logic               alu_c_s, alu_v_s;

  assign edge_s     = enable & ~en_q;
  assign sh_s       = b_q[SW-1:0];
  assign add_s      = {1'b0, a_q} + {1'b0, b_q};
  assign sub_s      = {1'b0, a_q} - {1'b0, b_q};
  // One shift-add step: conditionally add A into the high half, then shift right.
  assign mul_sum_s  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
  assign mul_next_s = {mul_sum_s, prod_q[WIDTH-1:1]};

  // Single-cycle ALU datapath: result, carry/borrow and signed overflow.
  always_comb begin
    alu_y_s = '0;
    alu_c_s = 1'b0;
    alu_v_s = 1'b0;
    case (op_e'(op))
      OP_ADD: begin
        {alu_c_s, alu_y_s} = add_s;
        alu_v_s = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_s[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB, OP_CMP: begin
        {alu_c_s, alu_y_s} = sub_s;
        alu_v_s = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sub_s[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_AND: alu_y_s = a_q & b_q;
      OP_OR:  alu_y_s = a_q | b_q;
      OP_XOR: alu_y_s = a_q ^ b_q;
      OP_NOT: alu_y_s = ~a_q;
      // Carry is the last bit pushed out; an extra bit beside A catches it.
      OP_SHL: {alu_c_s, alu_y_s} = {1'b0, a_q} << sh_s;
      OP_SHR: {alu_y_s, alu_c_s} = {a_q, 1'b0} >> sh_s;
      OP_SRA: {alu_y_s, alu_c_s} = $signed({a_q, 1'b0}) >>> sh_s;
      OP_ROL: begin
        alu_y_s = (a_q << sh_s) | (a_q >> (W_L - {1'b0, sh_s}));
        alu_c_s = (sh_s != '0) & alu_y_s[0];
      end
      OP_ROR: begin
        alu_y_s = (a_q >> sh_s) | (a_q << (W_L - {1'b0, sh_s}));
        alu_c_s = (sh_s != '0) & alu_y_s[WIDTH-1];
      end
      OP_INC: begin
        {alu_c_s, alu_y_s} = {1'b0, a_q} + (WIDTH+1)'(1);
        alu_v_s = (a_q == {1'b0, {(WIDTH-1){1'b1}}});
      end
      OP_DEC: begin
        alu_y_s = a_q - WIDTH'(1);
        alu_c_s = (a_q == '0);
        alu_v_s = (a_q == {1'b1, {(WIDTH-1){1'b0}}});
      end
      default: alu_y_s = '0;
    endcase
  end

  // Phase sequencing, operand capture, result write-back and multiplier stepping.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    y_d     = y_q;
    yh_d    = yh_q;
    fl_d    = fl_q;
    done_d  = 1'b0;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_LOAD_A: begin
        if (edge_s) begin
          a_d     = data_in;
          state_d = S_LOAD_B;
        end else begin
          state_d = S_LOAD_A;
        end
      end
      S_LOAD_B: begin
        if (edge_s) begin
          b_d     = data_in;
          state_d = S_READY;
        end else begin
          state_d = S_LOAD_B;
        end
      end
      S_READY: begin
        if (edge_s) begin
          case (op_e'(op))
            OP_MUL: begin
              prod_d  = {{WIDTH{1'b0}}, b_q};
              cnt_d   = '0;
              state_d = S_BUSY;
            end
            OP_RLD: state_d = S_LOAD_A;
            OP_CMP: begin
              // Flags only: y and y_hi keep their previous result.
              fl_d   = {alu_y_s[WIDTH-1], (alu_y_s == '0), alu_c_s, alu_v_s};
              done_d = 1'b1;
            end
            default: begin
              y_d    = alu_y_s;
              yh_d   = '0;
              fl_d   = {alu_y_s[WIDTH-1], (alu_y_s == '0), alu_c_s, alu_v_s};
              done_d = 1'b1;
              if (CHAIN) begin
                a_d = alu_y_s;
              end else begin
                a_d = a_q;
              end
            end
          endcase
        end else begin
          state_d = S_READY;
        end
      end
      S_BUSY: begin
        prod_d = mul_next_s;
        cnt_d  = cnt_q + SW'(1);
        if (cnt_q == CNT_LAST) begin
          y_d     = mul_next_s[WIDTH-1:0];
          yh_d    = mul_next_s[2*WIDTH-1:WIDTH];
          fl_d    = {mul_next_s[WIDTH-1], (mul_next_s == '0),
                     (mul_next_s[2*WIDTH-1:WIDTH] != '0), 1'b0};
          done_d  = 1'b1;
          state_d = S_READY;
          if (CHAIN) begin
            a_d = mul_next_s[WIDTH-1:0];
          end else begin
            a_d = a_q;
          end
        end else begin
          state_d = S_BUSY;
        end
      end
      default: state_d = S_LOAD_A;
    endcase
    busy_d = (state_d == S_BUSY);
  end

  // State and datapath registers; enable history resets high so a held level never acts.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_LOAD_A;
      en_q    <= 1'b1;
      a_q     <= '0;
      b_q     <= '0;
      y_q     <= '0;
      yh_q    <= '0;
      fl_q    <= 4'h0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      prod_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= enable;
      a_q     <= a_d;
      b_q     <= b_d;
      y_q     <= y_d;
      yh_q    <= yh_d;
      fl_q    <= fl_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
    end
  end

  assign a_out = a_q;
  assign b_out = b_q;
  assign y     = y_q;
  assign y_hi  = yh_q;
  assign flags = fl_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign phase = state_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: one plain instance and one accumulator-mode
// instance share the stimulus; use_c selects which one is observed.
module tb_alu_seq;

  typedef struct packed {
    logic [7:0] y;
    logic [7:0] yh;
    logic [3:0] fl;
    logic [7:0] a;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [3:0] op = 4'h0;
  logic       use_c = 1'b0;

  logic [7:0] d_a, d_b, d_y, d_yh, c_a, c_b, c_y, c_yh;
  logic [3:0] d_fl, c_fl;
  logic       d_busy, d_done, c_busy, c_done;
  logic [1:0] d_ph, c_ph;

  logic [7:0] o_a, o_b, o_y, o_yh;
  logic [3:0] o_fl;
  logic       o_busy, o_done;
  logic [1:0] o_ph;

  exp_t sb[$];
  int   n_total = 0;
  int   n_bad   = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(8), .CHAIN(1'b0)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .data_in(data_in), .op(op),
    .a_out(d_a), .b_out(d_b), .y(d_y), .y_hi(d_yh), .flags(d_fl),
    .busy(d_busy), .done(d_done), .phase(d_ph));

  alu_seq #(.WIDTH(8), .CHAIN(1'b1)) dut_c (
    .clk(clk), .reset_n(reset_n), .enable(enable), .data_in(data_in), .op(op),
    .a_out(c_a), .b_out(c_b), .y(c_y), .y_hi(c_yh), .flags(c_fl),
    .busy(c_busy), .done(c_done), .phase(c_ph));

  assign o_a    = use_c ? c_a    : d_a;
  assign o_b    = use_c ? c_b    : d_b;
  assign o_y    = use_c ? c_y    : d_y;
  assign o_yh   = use_c ? c_yh   : d_yh;
  assign o_fl   = use_c ? c_fl   : d_fl;
  assign o_busy = use_c ? c_busy : d_busy;
  assign o_done = use_c ? c_done : d_done;
  assign o_ph   = use_c ? c_ph   : d_ph;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // One-cycle enable pulse; returns at the negedge of cycle k+1.
  task automatic pulse(input logic [7:0] d, input logic [3:0] o);
    @(negedge clk);
    data_in = d;
    op      = o;
    enable  = 1'b1;
    @(negedge clk);
    enable  = 1'b0;
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] b);
    pulse(a, 4'h0);
    check_eq("load_a", {24'h0, o_a}, {24'h0, a});
    check_eq("phase_b", {30'h0, o_ph}, 32'd1);
    pulse(b, 4'h0);
    check_eq("load_b", {24'h0, o_b}, {24'h0, b});
    check_eq("phase_rdy", {30'h0, o_ph}, 32'd2);
  endtask

  // Push expectation, issue op, wait (bounded) for done, pop and compare.
  task automatic exec(input string tag, input logic [3:0] o, input int lat, input exp_t e);
    int   n;
    exp_t x;
    logic [7:0] a0, b0;
    sb.push_back(e);
    a0 = o_a;
    b0 = o_b;
    pulse(8'h00, o);
    n = 0;
    while (!o_done && n < lat + 4) begin
      check_eq({tag, "_busy"}, {31'h0, o_busy}, 32'd1);
      if (n == 2) begin enable = 1'b1; op = 4'h0; data_in = 8'h55; end
      if (n == 3) enable = 1'b0;
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_lat"}, n, lat);
    check_eq({tag, "_done"}, {31'h0, o_done}, 32'd1);
    check_eq({tag, "_nobusy"}, {31'h0, o_busy}, 32'd0);
    if (sb.size() > 0) begin
      x = sb.pop_front();
      check_eq({tag, "_y"},  {24'h0, o_y},  {24'h0, x.y});
      check_eq({tag, "_yh"}, {24'h0, o_yh}, {24'h0, x.yh});
      check_eq({tag, "_fl"}, {28'h0, o_fl}, {28'h0, x.fl});
      check_eq({tag, "_a"},  {24'h0, o_a},  {24'h0, x.a});
    end
    if (lat > 0) check_eq({tag, "_b_kept"}, {24'h0, o_b}, {24'h0, b0});
    if (lat > 0 && !use_c) check_eq({tag, "_a_kept"}, {24'h0, o_a}, {24'h0, a0});
    tick();
    check_eq({tag, "_done_1cyc"}, {31'h0, o_done}, 32'd0);
  endtask

  task automatic reload(input logic [7:0] y_hold);
    pulse(8'h00, 4'hF);
    check_eq("rld_phase", {30'h0, o_ph}, 32'd0);
    check_eq("rld_y", {24'h0, o_y}, {24'h0, y_hold});
    check_eq("rld_nodone", {31'h0, o_done}, 32'd0);
  endtask

  initial begin
    tick(); tick(); tick();
    check_eq("rst_a", {24'h0, o_a}, 32'h0);
    check_eq("rst_y", {24'h0, o_y}, 32'h0);
    check_eq("rst_fl", {28'h0, o_fl}, 32'h0);
    check_eq("rst_ph", {30'h0, o_ph}, 32'h0);
    reset_n = 1'b1;
    tick();

    load(8'h7F, 8'h01);
    exec("add", 4'h0, 0, '{8'h80, 8'h00, 4'b1001, 8'h7F});
    exec("and", 4'h2, 0, '{8'h01, 8'h00, 4'b0000, 8'h7F});
    exec("xor", 4'h4, 0, '{8'h7E, 8'h00, 4'b0000, 8'h7F});
    exec("not", 4'h5, 0, '{8'h80, 8'h00, 4'b1000, 8'h7F});
    exec("inc", 4'hD, 0, '{8'h80, 8'h00, 4'b1001, 8'h7F});
    exec("dec", 4'hE, 0, '{8'h7E, 8'h00, 4'b0000, 8'h7F});
    exec("shl", 4'h6, 0, '{8'hFE, 8'h00, 4'b1000, 8'h7F});
    exec("cmp", 4'hC, 0, '{8'hFE, 8'h00, 4'b0000, 8'h7F});
    reload(8'hFE);

    load(8'h00, 8'h01);
    exec("sub", 4'h1, 0, '{8'hFF, 8'h00, 4'b1010, 8'h00});
    reload(8'hFF);

    load(8'hFF, 8'hFF);
    exec("mul", 4'hB, 8, '{8'h01, 8'hFE, 4'b0010, 8'hFF});
    reload(8'h01);

    load(8'h80, 8'h03);
    exec("sra", 4'h8, 0, '{8'hF0, 8'h00, 4'b1000, 8'h80});
    reload(8'hF0);
    load(8'h81, 8'h01);
    exec("rol", 4'h9, 0, '{8'h03, 8'h00, 4'b0010, 8'h81});
    exec("ror", 4'hA, 0, '{8'hC0, 8'h00, 4'b1010, 8'h81});
    reload(8'hC0);
    load(8'h01, 8'h00);
    exec("shl0", 4'h6, 0, '{8'h01, 8'h00, 4'b0000, 8'h01});
    reload(8'h01);

    // Reset in the middle of a multiply, enable held high across release.
    load(8'hFF, 8'hFF);
    pulse(8'h00, 4'hB);
    tick(); tick(); tick();
    reset_n = 1'b0;
    enable  = 1'b1;
    data_in = 8'h33;
    tick();
    check_eq("mrst_a", {24'h0, o_a}, 32'h0);
    check_eq("mrst_b", {24'h0, o_b}, 32'h0);
    check_eq("mrst_y", {24'h0, o_y}, 32'h0);
    check_eq("mrst_yh", {24'h0, o_yh}, 32'h0);
    check_eq("mrst_fl", {28'h0, o_fl}, 32'h0);
    check_eq("mrst_busy", {31'h0, o_busy}, 32'h0);
    check_eq("mrst_done", {31'h0, o_done}, 32'h0);
    check_eq("mrst_ph", {30'h0, o_ph}, 32'h0);
    tick(); tick();
    check_eq("mrst_done2", {31'h0, o_done}, 32'h0);
    reset_n = 1'b1;
    tick(); tick(); tick();
    check_eq("held_en_a", {24'h0, o_a}, 32'h0);
    check_eq("held_en_ph", {30'h0, o_ph}, 32'h0);
    enable = 1'b0;
    tick();
    pulse(8'h33, 4'h0);
    check_eq("reen_a", {24'h0, o_a}, 32'h33);
    check_eq("reen_ph", {30'h0, o_ph}, 32'd1);

    // Accumulator mode on the second instance.
    reset_n = 1'b0;
    use_c   = 1'b1;
    tick(); tick();
    reset_n = 1'b1;
    tick();
    load(8'h05, 8'h03);
    exec("ch_add1", 4'h0, 0, '{8'h08, 8'h00, 4'b0000, 8'h08});
    exec("ch_add2", 4'h0, 0, '{8'h0B, 8'h00, 4'b0000, 8'h0B});
    exec("ch_add3", 4'h0, 0, '{8'h0E, 8'h00, 4'b0000, 8'h0E});
    exec("ch_cmp",  4'hC, 0, '{8'h0E, 8'h00, 4'b0000, 8'h0E});

    check_eq("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised sequential ALU core for the board-level ALU design. Operands are entered one at a time from a shared data bus, each captured on a rising edge of a single `enable` input: first edge loads A, second loads B, later edges execute `op`. It provides registered operand, result and flag outputs for LED and seven-segment display, a multi-cycle shift-add multiplier with busy/done handshake, and an optional accumulator (chain) mode.

## Interface
- `WIDTH`, 8, operand/result width; power of two, ≥ 4
- `CHAIN`, 0, 1 = accumulator mode: each executed result is written back into A
- `clk`  in  1  system clock
- `reset_n`  in  1  synchronous, active-low reset
- `enable`  in  1  level input (already debounced); only rising edges act
- `data_in`  in  WIDTH  operand bus
- `op`  in  4  operation select, sampled on the execute edge
- `a_out`  out  WIDTH  register A (LED display)
- `b_out`  out  WIDTH  register B (LED display)
- `y`  out  WIDTH  result, low half for MUL
- `y_hi`  out  WIDTH  MUL high half; 0 after any other op
- `flags`  out  4  {N, Z, C, V}
- `busy`  out  1  multiplier running
- `done`  out  1  one-cycle pulse when a result is written
- `phase`  out  2  0 = LOAD_A, 1 = LOAD_B, 2 = READY, 3 = BUSY

## Operation
- Edge detect: `edge = enable & ~enable_q`. `enable_q` resets to 1, so an `enable` held high through reset release does not act.
- **LOAD_A**
  - on edge: A ← `data_in`, go to LOAD_B.
- **LOAD_B**
  - on edge: B ← `data_in`, go to READY.
- **READY**
  - on edge: latch `op`, then execute it.
  - Single-cycle ops write `y`, `y_hi`, `flags` and pulse `done`; state stays READY.
  - MUL goes to BUSY.
  - RELOAD goes to LOAD_A with no output change.
- **BUSY**
  - Shift-add, one bit of B per cycle, for WIDTH cycles.
  - Then write `y`/`y_hi`/`flags`, pulse `done`, return to READY.
  - Edges and changes on `op` or `data_in` are ignored while busy.
- **Op encoding**:
  - 0 ADD
  - 1 SUB (A−B)
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 NOT A
  - 6 SHL
  - 7 SHR (logical)
  - 8 SRA
  - 9 ROL
  - A ROR
  - B MUL (unsigned)
  - C CMP
  - D INC A
  - E DEC A
  - F RELOAD
- **Shift/rotate amount**: `s = B[log2(WIDTH)-1:0]`.
- **Flags**:
  - Z: result == 0. For MUL, Z tests the full 2·WIDTH product.
  - N: `y[WIDTH-1]`.
  - C:
    - carry out for ADD/INC
    - borrow (A < B unsigned, or A == 0 for DEC) for SUB/DEC/CMP
    - last bit shifted or rotated out for shifts/rotates; 0 when s = 0
    - 1 if `y_hi` ≠ 0 for MUL
    - 0 for logic ops
  - V: signed overflow for ADD/SUB/INC/DEC/CMP; 0 otherwise.
- **CMP**: computes A−B for flags only; `y` and `y_hi` are unchanged.
- **Chain mode**: with CHAIN = 1, every write of `y` (except CMP) also loads A ← `y`. B is unchanged.
- **Reset**:
  - Clears A, B, `y`, `y_hi`, `flags`, `busy`, `done` and the multiplier state.
  - Sets `phase` = LOAD_A.
  - Aborts an in-progress MUL with no `done`.

## Timing
- All outputs are registered. Clock k is the clock at which an edge is sampled.
- LOAD_A/LOAD_B: the new `a_out`/`b_out` and `phase` are visible from cycle k+1.
- Single-cycle op: `y`/`flags` are valid and `done` = 1 in cycle k+1 only.
- MUL:
  - `busy` = 1 in cycles k+1 … k+WIDTH.
  - Result written at clock k+WIDTH; `done` = 1 and `busy` = 0 in cycle k+WIDTH+1.
- `done` and `busy` are never high together.
- Back-to-back edges in READY are each executed; the minimum edge spacing is 2 cycles, set by the edge detector.

## Test plan
- **ADD overflow**: WIDTH = 8; load A = 0x7F, B = 0x01, op 0 → `y` = 0x80, flags N=1 Z=0 C=0 V=1, `done` high for exactly one cycle at k+1.
- **SUB borrow, then RELOAD**: load A = 0x00, B = 0x01, op 1 → `y` = 0xFF, N=1 C=1 V=0. Then op F → `phase` = 0, `y` holds 0xFF.
- **MUL**: load 0xFF, 0xFF, op B → `busy` for 8 cycles, then `y` = 0x01, `y_hi` = 0xFE, C=1. Extra edges and an op change to 0 during BUSY have no effect.
- **Shifts/rotates**:
  - A = 0x80, B = 3, op 8 → 0xF0, C=0.
  - A = 0x81, B = 1, op 9 → 0x03, C=1.
  - A = 0x01, B = 0, op 6 → 0x01, C=0.
- **Reset mid-MUL**: assert `reset_n` = 0 at cycle k+4 of a MUL → next cycle all outputs 0, `phase` = 0, no `done`. Hold `enable` high through reset release → A is not loaded until `enable` falls and rises again.
- **Chain mode**: CHAIN = 1; load A = 5, B = 3; three ADD edges → `y` = 8, 11, 14 and `a_out` tracks `y`. CMP afterwards → `a_out` stays 14, C=0, Z=0.
